// File: rtl/crc_serial_engine.sv
// Serial CRC engine with a Galois LFSR. Generate mode shifts the CRC out LSB first.
// Check mode compares the final LFSR against RESIDUE and pulses done.
module crc_serial_engine #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] POLY    = 8'h44,
    parameter logic [WIDTH-1:0] INIT    = 8'hD8,
    parameter logic [WIDTH-1:0] XOROUT  = 8'h00,
    parameter logic [WIDTH-1:0] RESIDUE = 8'h00
) (
    input  logic CLK,
    input  logic RST,
    input  logic Data,
    input  logic ACTIVE,
    input  logic MODE,
    output logic CRC,
    output logic valid,
    output logic done,
    output logic err,
    output logic busy
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             crc_q, crc_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             emit;
    logic             xo_bit;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] l, input logic d);
        logic             fb;
        logic [WIDTH-1:0] n;
        fb = l[0] ^ d;
        n  = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            n[i] = l[i+1] ^ (POLY[i] & fb);
        end
        n[WIDTH-1] = fb;
        return n;
    endfunction

    // XOROUT bit matching the position currently being shifted out
    always_comb begin
        xo_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(i)) xo_bit = XOROUT[i];
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        crc_d   = crc_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        emit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ACTIVE) begin
                    lfsr_d  = lfsr_step(lfsr_q, Data);
                    mode_d  = MODE;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (ACTIVE) begin
                    lfsr_d = lfsr_step(lfsr_q, Data);
                end else if (!mode_q) begin
                    state_d = OUT;
                    emit    = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    err_d   = (lfsr_q != RESIDUE);
                    lfsr_d  = INIT;
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    lfsr_d  = INIT;
                    state_d = IDLE;
                end else begin
                    emit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Output bit 0 is emitted on the CALC->OUT edge, the rest from OUT
        if (emit) begin
            crc_d   = lfsr_q[0] ^ xo_bit;
            valid_d = 1'b1;
            lfsr_d  = {1'b0, lfsr_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            lfsr_q  <= INIT;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            crc_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            crc_q   <= crc_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign CRC   = crc_q;
    assign valid = valid_q;
    assign done  = done_q;
    assign err   = err_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_crc_serial_engine.sv
// Bench for crc_serial_engine: frame-level reference model checked every cycle on the
// default instance, plus a 16-bit instance exercised with a random 64-bit message.
module tb_crc_serial_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic d8, a8, m8, crc8, v8, dn8, er8, bz8;
    logic d16, a16, m16, crc16, v16, dn16, er16, bz16;

    crc_serial_engine dut8 (
        .CLK(clk), .RST(rst), .Data(d8), .ACTIVE(a8), .MODE(m8),
        .CRC(crc8), .valid(v8), .done(dn8), .err(er8), .busy(bz8)
    );

    crc_serial_engine #(
        .WIDTH(16), .POLY(16'h8408), .INIT(16'hFFFF), .XOROUT(16'hFFFF), .RESIDUE(16'hF0B8)
    ) dut16 (
        .CLK(clk), .RST(rst), .Data(d16), .ACTIVE(a16), .MODE(m16),
        .CRC(crc16), .valid(v16), .done(dn16), .err(er16), .busy(bz16)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reflected CRC bit step: shift right, XOR the tap mask (with the MSB) when feedback is 1
    function automatic logic [31:0] step(input logic [31:0] l, input logic d,
                                         input logic [31:0] poly, input int w);
        logic [31:0] r;
        r = l >> 1;
        if (l[0] ^ d) r = r ^ (poly | (32'd1 << (w - 1)));
        return r;
    endfunction

    // Frame-level model of the default instance
    logic [31:0] lfsr_m;
    bit          model_ok = 1'b0;
    bit          in_frame, fmode, term;
    bit          oq[$];
    logic        crc_e, valid_e, done_e, err_e, busy_e;

    always @(posedge clk) begin : model
        logic [31:0] fin;
        if (rst) begin
            crc_e = 0; valid_e = 0; done_e = 0; err_e = 0; busy_e = 0;
            lfsr_m = 32'hD8; in_frame = 0; term = 0; oq.delete(); model_ok = 1;
        end else if (model_ok) begin
            done_e = 0;
            if (oq.size() > 0) begin
                crc_e = oq.pop_front(); valid_e = 1; busy_e = 1;
                if (oq.size() == 0) term = 1;
            end else if (term) begin
                valid_e = 0; busy_e = 0; term = 0;
            end else if (in_frame) begin
                if (a8) begin
                    lfsr_m = step(lfsr_m, d8, 32'h44, 8);
                end else if (!fmode) begin
                    fin = lfsr_m;
                    for (int k = 0; k < 8; k++) oq.push_back(fin[k]);
                    crc_e = oq.pop_front(); valid_e = 1; busy_e = 1;
                    lfsr_m = 32'hD8; in_frame = 0;
                end else begin
                    done_e = 1; err_e = (lfsr_m != 32'h00);
                    lfsr_m = 32'hD8; in_frame = 0; busy_e = 0;
                end
            end else if (a8) begin
                lfsr_m = step(lfsr_m, d8, 32'h44, 8);
                fmode = m8; in_frame = 1; busy_e = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("crc8", crc8, crc_e);
            check("valid8", v8, valid_e);
            check("done8", dn8, done_e);
            check("err8", er8, err_e);
            check("busy8", bz8, busy_e);
            if (!busy_e) check("lfsr8_idle", dut8.lfsr_q, lfsr_m);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input logic [15:0] bits, input int n, input bit mode, input bit toggle,
                        output logic [7:0] cap, output int nv, output int ndone, output logic errv);
        for (int i = 0; i < n; i++) begin
            a8 = 1'b1; d8 = bits[i]; m8 = (i == 0) ? mode : ~mode;
            tick();
        end
        a8 = 1'b0; d8 = 1'b0; cap = '0; nv = 0; ndone = 0; errv = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (toggle && c >= 1 && c <= 8) begin
                a8 = 1'($urandom_range(0, 1)); d8 = 1'($urandom_range(0, 1));
            end else begin
                a8 = 1'b0;
            end
            tick();
            if (v8) begin
                if (nv < 8) cap[nv] = crc8;
                nv++;
            end
            if (dn8) begin
                ndone++; errv = er8;
            end
        end
    endtask

    initial begin : main
        logic [7:0]  cap;
        logic [15:0] cap16;
        logic [63:0] msg;
        logic [31:0] l16;
        int          nv, ndone;
        logic        errv, e16;

        rst = 1'b1; d8 = 0; a8 = 0; m8 = 0; d16 = 0; a16 = 0; m16 = 0;
        tick(); tick();
        check("reset_valid", v8, 0);
        check("reset_crc", crc8, 0);
        check("reset_busy", bz8, 0);
        check("reset_lfsr", dut8.lfsr_q, 32'hD8);
        rst = 1'b0;
        tick();

        check("model_pin_bit1", step(32'hD8, 1'b1, 32'h44, 8), 32'hA8);
        check("model_pin_bit0", step(32'hD8, 1'b0, 32'h44, 8), 32'h6C);

        // Single bit 1, generate
        run8(16'h0001, 1, 1'b0, 1'b0, cap, nv, ndone, errv);
        check("s1_crc", cap, 8'hA8);
        check("s1_len", nv, 8);
        check("s1_nodone", ndone, 0);
        check("s1_lfsr_reinit", dut8.lfsr_q, 32'hD8);

        // Single bit 0, then bit 1 again
        run8(16'h0000, 1, 1'b0, 1'b0, cap, nv, ndone, errv);
        check("s2_crc", cap, 8'h6C);
        run8(16'h0001, 1, 1'b0, 1'b0, cap, nv, ndone, errv);
        check("s2_rerun_crc", cap, 8'hA8);
        check("s2_rerun_len", nv, 8);

        // Check mode: good frame, corrupted frame, err holds
        run8(16'h0151, 9, 1'b1, 1'b0, cap, nv, ndone, errv);
        check("s3_good_done", ndone, 1);
        check("s3_good_err", errv, 0);
        check("s3_good_novalid", nv, 0);
        run8(16'h0141, 9, 1'b1, 1'b0, cap, nv, ndone, errv);
        check("s3_bad_done", ndone, 1);
        check("s3_bad_err", errv, 1);
        repeat (5) tick();
        check("s3_err_hold", er8, 1);
        run8(16'h0000, 1, 1'b0, 1'b0, cap, nv, ndone, errv);
        check("s3_err_hold_gen", er8, 1);
        check("s3_gen_crc", cap, 8'h6C);
        run8(16'h0151, 9, 1'b1, 1'b0, cap, nv, ndone, errv);
        check("s3_err_clear", errv, 0);

        // Empty frame: nothing happens
        nv = 0; ndone = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (v8) nv++;
            if (dn8) ndone++;
        end
        check("empty_valid", nv, 0);
        check("empty_done", ndone, 0);
        check("empty_busy", bz8, 0);

        // ACTIVE toggled during OUT
        run8(16'h0001, 1, 1'b0, 1'b1, cap, nv, ndone, errv);
        check("s4_crc", cap, 8'hA8);
        check("s4_len", nv, 8);
        check("s4_lfsr", dut8.lfsr_q, 32'hD8);

        // Reset during the 4th valid cycle
        a8 = 1'b1; d8 = 1'b1; m8 = 1'b0;
        tick();
        a8 = 1'b0; d8 = 1'b0;
        repeat (4) tick();
        check("s5_fourth_valid", v8, 1);
        rst = 1'b1;
        tick();
        check("s5_rst_valid", v8, 0);
        check("s5_rst_crc", crc8, 0);
        check("s5_rst_busy", bz8, 0);
        check("s5_rst_done", dn8, 0);
        check("s5_rst_err", er8, 0);
        check("s5_rst_lfsr", dut8.lfsr_q, 32'hD8);
        rst = 1'b0;
        tick();
        run8(16'h0001, 1, 1'b0, 1'b0, cap, nv, ndone, errv);
        check("s5_after_crc", cap, 8'hA8);
        check("s5_after_len", nv, 8);

        // 16-bit instance, random message
        msg = {$urandom, $urandom};
        l16 = 32'hFFFF;
        for (int i = 0; i < 64; i++) begin
            a16 = 1'b1; d16 = msg[i]; m16 = 1'b0;
            l16 = step(l16, msg[i], 32'h8408, 16);
            tick();
        end
        a16 = 1'b0; d16 = 1'b0; cap16 = '0; nv = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (v16) begin
                if (nv < 16) cap16[nv] = crc16;
                nv++;
            end
        end
        check("s6_crc16", cap16, l16 ^ 32'hFFFF);
        check("s6_len16", nv, 16);
        check("s6_busy16", bz16, 0);

        l16 = 32'hFFFF;
        for (int i = 0; i < 80; i++) begin
            a16 = 1'b1; m16 = (i == 0);
            d16 = (i < 64) ? msg[i] : cap16[i-64];
            l16 = step(l16, d16, 32'h8408, 16);
            tick();
        end
        a16 = 1'b0; d16 = 1'b0; ndone = 0; e16 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (dn16) begin
                ndone++; e16 = er16;
            end
        end
        check("s6_model_residue", l16, 32'hF0B8);
        check("s6_check_done", ndone, 1);
        check("s6_check_err", e16, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
